// File: rtl/mmix_mem_responder.sv
// Memory target for the MMIX load/store unit: one aligned byte/wyde/tetra/octa access
// over a 16-bit big-endian halfword bus. Optional MMIX_MEM_RANGE_CHECK_EN adds mem_error.
module mmix_mem_responder #(
  parameter int ADDR_WIDTH = 22
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [63:0]           mem_address,
  input  logic [1:0]            mem_datasize,
  input  logic [63:0]           mem_writedata,
  output logic [63:0]           mem_readdata,
  output logic                  mem_done,
`ifdef MMIX_MEM_RANGE_CHECK_EN
  output logic                  mem_error,
`endif
  output logic [ADDR_WIDTH-1:0] ext_addr,
  output logic                  ext_rd,
  output logic                  ext_wr,
  output logic [1:0]            ext_be,
  output logic [15:0]           ext_wdata,
  input  logic [15:0]           ext_rdata,
  input  logic                  ext_ack
);

  typedef enum logic [1:0] {S_IDLE, S_BEAT, S_DONE} state_t;

  state_t                r_state, w_next;
  logic                  r_wr;
  logic [1:0]            r_size;
  logic [ADDR_WIDTH:0]   r_addr;
  logic [63:0]           r_wdata;
  logic [1:0]            r_beat;
  logic [63:0]           r_acc;
  logic [63:0]           r_rdata;
  logic [63:0]           w_aligned;
  logic                  w_range_err;
  logic [1:0]            w_last_idx;
  logic                  w_last_beat;
  logic [15:0]           w_rlane;
  logic [63:0]           w_acc_next;

  always_comb begin
    w_aligned = mem_address;
    unique case (mem_datasize)
      2'd1:    w_aligned = {mem_address[63:1], 1'b0};
      2'd2:    w_aligned = {mem_address[63:2], 2'b0};
      2'd3:    w_aligned = {mem_address[63:3], 3'b0};
      default: w_aligned = mem_address;
    endcase
  end

`ifdef MMIX_MEM_RANGE_CHECK_EN
  logic r_err;
  assign w_range_err = |w_aligned[63:ADDR_WIDTH+1];
  assign mem_error   = r_err;
`else
  assign w_range_err = 1'b0;
`endif

  assign w_last_idx  = (r_size == 2'd3) ? 2'd3 : (r_size == 2'd2) ? 2'd1 : 2'd0;
  assign w_last_beat = (r_beat == w_last_idx);
  // Byte reads pick the lane by address parity; everything else takes the full halfword.
  assign w_rlane     = (r_size == 2'd0) ? {8'h00, r_addr[0] ? ext_rdata[7:0] : ext_rdata[15:8]}
                                        : ext_rdata;
  assign w_acc_next  = {r_acc[47:0], w_rlane};
  assign mem_readdata = r_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (mem_read || mem_write) w_next = w_range_err ? S_DONE : S_BEAT;
      S_BEAT:  if (ext_ack && w_last_beat) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_done  = (r_state == S_DONE);
    ext_rd    = 1'b0;
    ext_wr    = 1'b0;
    ext_be    = 2'b00;
    ext_addr  = '0;
    ext_wdata = 16'h0;
    if (r_state == S_BEAT) begin
      ext_rd   = !r_wr;
      ext_wr   = r_wr;
      ext_addr = r_addr[ADDR_WIDTH:1] + ADDR_WIDTH'(r_beat);
      ext_be   = (r_size != 2'd0) ? 2'b11 : (r_addr[0] ? 2'b01 : 2'b10);
      // Lower address carries the more significant halfword.
      unique case (r_size)
        2'd0: ext_wdata = {2{r_wdata[7:0]}};
        2'd1: ext_wdata = r_wdata[15:0];
        2'd2: ext_wdata = r_beat[0] ? r_wdata[15:0] : r_wdata[31:16];
        default: begin
          unique case (r_beat)
            2'd0:    ext_wdata = r_wdata[63:48];
            2'd1:    ext_wdata = r_wdata[47:32];
            2'd2:    ext_wdata = r_wdata[31:16];
            default: ext_wdata = r_wdata[15:0];
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= '0;
      r_wdata <= 64'h0;
      r_beat  <= 2'd0;
      r_acc   <= 64'h0;
      r_rdata <= 64'h0;
`ifdef MMIX_MEM_RANGE_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: if (mem_read || mem_write) begin
          r_wr    <= !mem_read;
          r_size  <= mem_datasize;
          r_addr  <= w_aligned[ADDR_WIDTH:0];
          r_wdata <= mem_writedata;
          r_beat  <= 2'd0;
          r_acc   <= 64'h0;
`ifdef MMIX_MEM_RANGE_CHECK_EN
          r_err   <= w_range_err;
`endif
          if (w_range_err && mem_read) r_rdata <= 64'h0;
        end
        S_BEAT: if (ext_ack) begin
          if (!r_wr) r_acc <= w_acc_next;
          if (w_last_beat) begin
            if (!r_wr) r_rdata <= w_acc_next;
          end else begin
            r_beat <= r_beat + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmix_mem_responder.sv
// Bench for mmix_mem_responder: halfword memory responder with programmable ack wait,
// directed vector table, hand sequences, and random transactions against a reference model.
module tb_mmix_mem_responder;
  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          mem_read, mem_write;
  logic [63:0]   mem_address, mem_writedata, mem_readdata;
  logic [1:0]    mem_datasize;
  logic          mem_done;
  logic [AW-1:0] ext_addr;
  logic          ext_rd, ext_wr, ext_ack;
  logic [1:0]    ext_be;
  logic [15:0]   ext_wdata, ext_rdata;
`ifdef MMIX_MEM_RANGE_CHECK_EN
  logic          mem_error;
`endif

  always #5 clk = ~clk;

  mmix_mem_responder #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_datasize(mem_datasize), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_done(mem_done),
`ifdef MMIX_MEM_RANGE_CHECK_EN
    .mem_error(mem_error),
`endif
    .ext_addr(ext_addr), .ext_rd(ext_rd), .ext_wr(ext_wr), .ext_be(ext_be),
    .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_ack(ext_ack)
  );

  typedef struct {logic wr; logic [AW-1:0] a; logic [1:0] be; logic [15:0] d;} beat_t;
  typedef struct {
    bit rd; bit both; logic [1:0] sz; logic [63:0] a; logic [63:0] wd; int w;
    logic [63:0] er; int ecyc; int enb; logic [AW-1:0] ea0; logic [1:0] ebe0;
  } vec_t;

  beat_t       log_q[$], exp_q[$];
  vec_t        tbl[$];
  logic [15:0] xmem [logic [AW-1:0]];
  logic [15:0] cur;
  int          nvec = 0, nerr = 0, done_cnt = 0, ntxn = 0, wait_n = 0, wcnt = 0;
  logic [63:0] exp_hold = 64'h0;

  function automatic logic [15:0] rdmem(input logic [AW-1:0] a);
    if (xmem.exists(a)) return xmem[a];
    return (16'(a) * 16'h9E37) ^ 16'h5A5A;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // External memory: acks after wait_n idle cycles per beat, logs every acked beat.
  always @(negedge clk) begin
    ext_ack = 1'b0;
    if (ext_rd || ext_wr) begin
      if (wcnt >= wait_n) begin
        ext_ack = 1'b1;
        wcnt = 0;
        if (ext_rd) ext_rdata = rdmem(ext_addr);
        else begin
          cur = rdmem(ext_addr);
          if (ext_be[1]) cur[15:8] = ext_wdata[15:8];
          if (ext_be[0]) cur[7:0]  = ext_wdata[7:0];
          xmem[ext_addr] = cur;
        end
        log_q.push_back('{ext_wr, ext_addr, ext_be, ext_wdata});
      end else wcnt++;
    end else wcnt = 0;
    if (mem_done) done_cnt++;
  end

  // Reference: expected beat list, read value, error flag and accept-to-done latency.
  task automatic model(input bit rd, input logic [1:0] sz, input logic [63:0] a,
                       input logic [63:0] wd, input int w,
                       output logic [63:0] rdv, output bit err, output int cyc);
    int nbytes, nb;
    logic [63:0] al;
    logic [AW-1:0] ha;
    exp_q.delete();
    rdv = 64'h0;
    nbytes = 1 << sz;
    al = a & ~(64'(nbytes) - 64'd1);
    err = 1'b0;
`ifdef MMIX_MEM_RANGE_CHECK_EN
    err = (al >> (AW + 1)) != 64'h0;
`endif
    ha = AW'(al >> 1);
    if (err) begin cyc = 1; return; end
    if (sz == 2'd0) begin
      nb = 1;
      exp_q.push_back('{!rd, ha, al[0] ? 2'b01 : 2'b10, {wd[7:0], wd[7:0]}});
      rdv = al[0] ? 64'(rdmem(ha) & 16'h00FF) : 64'(rdmem(ha) >> 8);
    end else begin
      nb = nbytes / 2;
      for (int k = 0; k < nb; k++) begin
        exp_q.push_back('{!rd, ha + AW'(k), 2'b11, 16'(wd >> (16 * (nb - 1 - k)))});
        rdv = (rdv << 16) | 64'(rdmem(ha + AW'(k)));
      end
    end
    cyc = nb * (w + 1) + 1;
  endtask

  // Issue one request; skip=1 when called in the done cycle of the previous one.
  // Returns at the falling edge of the done cycle with the strobe still held.
  task automatic txn(input bit rd, input bit both, input logic [1:0] sz, input logic [63:0] a,
                     input logic [63:0] wd, input int w, input int skip, output int cyc);
    logic [63:0] rdv;
    logic [15:0] m;
    bit err;
    int ecyc;
    model(rd, sz, a, wd, w, rdv, err, ecyc);
    log_q.delete();
    wait_n = w;
    ntxn++;
    mem_read = rd; mem_write = !rd || both;
    mem_datasize = sz; mem_address = a; mem_writedata = wd;
    repeat (skip) @(posedge clk);
    @(posedge clk);
    #1;
    mem_address = {$urandom, $urandom};
    mem_writedata = {$urandom, $urandom};
    mem_datasize = 2'($urandom);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!mem_done && cyc < 300);
    chk("latency", 64'(cyc), 64'(ecyc));
    chk("nbeats", 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk("beat_dir", 64'(log_q[i].wr), 64'(exp_q[i].wr));
      chk("beat_addr", 64'(log_q[i].a), 64'(exp_q[i].a));
      chk("beat_be", 64'(log_q[i].be), 64'(exp_q[i].be));
      m = {{8{exp_q[i].be[1]}}, {8{exp_q[i].be[0]}}};
      if (exp_q[i].wr) chk("beat_wdata", 64'(log_q[i].d & m), 64'(exp_q[i].d & m));
    end
    if (rd) exp_hold = rdv;
    chk("rdata", mem_readdata, exp_hold);
`ifdef MMIX_MEM_RANGE_CHECK_EN
    chk("mem_error", 64'(mem_error), 64'(err));
`endif
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c, skip, d0;
    bit bad, rd;
    logic [63:0] a;
    mem_read = 0; mem_write = 0; mem_address = 0; mem_datasize = 0; mem_writedata = 0;
    ext_ack = 0; ext_rdata = 0;
    xmem[22'd8] = 16'h0123; xmem[22'd9] = 16'h4567; xmem[22'd10] = 16'h89AB; xmem[22'd11] = 16'hCDEF;
    xmem[22'h82] = 16'h8000; xmem[22'h83] = 16'h0001; xmem[22'h12] = 16'hC300;

    //            rd both sz  addr                    wdata                  w  exp_rdata             cyc nb a0      be0
    tbl.push_back('{1, 0, 3, 64'h13,                 64'h0,                 0, 64'h0123456789ABCDEF, 5, 4, 22'h08, 2'b11});
    tbl.push_back('{0, 0, 0, 64'h25,                 64'hFFFFFFFFFFFFFF5A,  0, 64'h0,                2, 1, 22'h12, 2'b01});
    tbl.push_back('{1, 0, 2, 64'h106,                64'h0,                 2, 64'h80000001,         7, 2, 22'h82, 2'b11});
    tbl.push_back('{1, 0, 0, 64'h24,                 64'h0,                 0, 64'hC3,               2, 1, 22'h12, 2'b10});
    tbl.push_back('{1, 0, 0, 64'h25,                 64'h0,                 0, 64'h5A,               2, 1, 22'h12, 2'b01});
    tbl.push_back('{1, 0, 1, 64'h25,                 64'h0,                 0, 64'hC35A,             2, 1, 22'h12, 2'b11});
    tbl.push_back('{0, 0, 1, 64'h11,                 64'h123456789ABCBEEF,  0, 64'h0,                2, 1, 22'h08, 2'b11});
    tbl.push_back('{1, 1, 3, 64'h17,                 64'hDEADDEADDEADDEAD,  1, 64'hBEEF456789ABCDEF, 9, 4, 22'h08, 2'b11});
    tbl.push_back('{0, 0, 3, 64'h40,                 64'h1122334455667788,  1, 64'h0,                9, 4, 22'h20, 2'b11});
    tbl.push_back('{1, 0, 3, 64'h47,                 64'h0,                 0, 64'h1122334455667788, 5, 4, 22'h20, 2'b11});
    tbl.push_back('{0, 0, 2, 64'h4E,                 64'hAAAABBBBCAFEF00D,  0, 64'h0,                3, 2, 22'h26, 2'b11});
    tbl.push_back('{1, 0, 2, 64'h4C,                 64'h0,                 1, 64'hCAFEF00D,         5, 2, 22'h26, 2'b11});
`ifdef MMIX_MEM_RANGE_CHECK_EN
    tbl.push_back('{1, 0, 3, 64'h8000000000000000,   64'h0,                 0, 64'h0,                1, 0, 22'h00, 2'b00});
    tbl.push_back('{0, 0, 3, 64'h8000000000000008,   64'h5555555555555555,  0, 64'h0,                1, 0, 22'h00, 2'b00});
`else
    tbl.push_back('{1, 0, 3, 64'hFFFF000000000010,   64'h0,                 0, 64'hBEEF456789ABCDEF, 5, 4, 22'h08, 2'b11});
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", 64'(mem_done), 64'h0);
    chk("rst_rdata", mem_readdata, 64'h0);
    chk("rst_strobes", 64'({ext_rd, ext_wr}), 64'h0);
    chk("rst_be", 64'(ext_be), 64'h0);
    chk("rst_addr", 64'(ext_addr), 64'h0);
    chk("rst_wdata", 64'(ext_wdata), 64'h0);
    @(negedge clk) reset_n = 1'b1;

    foreach (tbl[i]) begin
      txn(tbl[i].rd, tbl[i].both, tbl[i].sz, tbl[i].a, tbl[i].wd, tbl[i].w, 0, c);
      chk("tbl_latency", 64'(c), 64'(tbl[i].ecyc));
      chk("tbl_nbeats", 64'(log_q.size()), 64'(tbl[i].enb));
      if (tbl[i].enb > 0 && log_q.size() > 0) begin
        chk("tbl_addr0", 64'(log_q[0].a), 64'(tbl[i].ea0));
        chk("tbl_be0", 64'(log_q[0].be), 64'(tbl[i].ebe0));
      end
      if (tbl[i].rd) chk("tbl_rdata", mem_readdata, tbl[i].er);
      idle();
    end
    chk("byte_write_mem", 64'(xmem[22'h12]), 64'hC35A);

    // CSWAP: write raised during the done cycle must wait for the next idle edge.
    d0 = done_cnt;
    txn(1, 0, 3, 64'h40, 64'h0, 0, 0, c);
    txn(0, 0, 3, 64'h40, 64'h0F0E0D0C0B0A0908, 0, 1, c);
    idle();
    @(negedge clk);
    chk("cswap_done_pulses", 64'(done_cnt - d0), 64'd2);

    // Reset during beat 2 of an octa write.
    wait_n = 0;
    mem_write = 1; mem_datasize = 3; mem_address = 64'h80; mem_writedata = 64'h1;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_ext_wr", 64'(ext_wr), 64'h0);
    chk("abort_done", 64'(mem_done), 64'h0);
    mem_write = 0;
    @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    log_q.delete();
    exp_hold = 64'h0;
    bad = 0;
    repeat (5) begin @(negedge clk); if (ext_rd || ext_wr || mem_done) bad = 1; end
    chk("post_reset_quiet", 64'(bad), 64'h0);
    chk("post_reset_beats", 64'(log_q.size()), 64'h0);
    chk("post_reset_rdata", mem_readdata, 64'h0);

    skip = 0;
    for (int i = 0; i < 80; i++) begin
      rd = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      a[AW:8] = '0;
`ifdef MMIX_MEM_RANGE_CHECK_EN
      if ($urandom_range(0, 7) != 0) a[63:AW+1] = '0;
`endif
      txn(rd, rd && ($urandom_range(0, 3) == 0), 2'($urandom), a, {$urandom, $urandom},
          $urandom_range(0, 2), skip, c);
      if ($urandom_range(0, 2) == 0) skip = 1;
      else begin idle(); skip = 0; end
    end
    if (skip != 0) idle();
    @(negedge clk);
    chk("done_pulses", 64'(done_cnt), 64'(ntxn));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
